// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT: walks LOG2N stages of N/2
// butterflies, inserting a read-to-write drain between stages and delaying write-back addresses.
module fft_stage_sequencer #(
   parameter int unsigned LOG2N      = 11,
   parameter int unsigned MEM_RD_LAT = 1,
   parameter int unsigned BFLY_LAT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_u1_start,
   output logic             o_u1_busy,
   output logic             o_u1_done,
   output logic             o_u1_rd_en,
   output logic [LOG2N-1:0] o_rd_addr_a,
   output logic [LOG2N-1:0] o_rd_addr_b,
   output logic [LOG2N-2:0] o_twiddle_idx,
   output logic             o_u1_bfly_valid,
   output logic             o_u1_wr_en,
   output logic [LOG2N-1:0] o_wr_addr_a,
   output logic [LOG2N-1:0] o_wr_addr_b,
   output logic [3:0]       o_u4_stage
);

   localparam int unsigned L      = MEM_RD_LAT + BFLY_LAT;
   localparam int unsigned AW     = LOG2N;
   localparam int unsigned JW     = LOG2N - 1;
   localparam int unsigned DCW    = $clog2(L + 1);
   localparam logic [3:0]  LAST_S = 4'(LOG2N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_nxt;
   logic [3:0]      s_q, s_nxt;
   logic [JW-1:0]   j_q, j_nxt;
   logic [DCW-1:0]  drain_q, drain_nxt;

   logic            rd_nxt_c;
   logic [AW-1:0]   half_c, pos_c, grp_c, addr_a_c, addr_b_c;
   logic [JW-1:0]   tw_c;

   logic [L-1:0]    dl_en;
   logic [AW-1:0]   dl_a [L];
   logic [AW-1:0]   dl_b [L];

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         j_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_nxt;
         s_q     <= s_nxt;
         j_q     <= j_nxt;
         drain_q <= drain_nxt;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_nxt = state_q;
      s_nxt     = s_q;
      j_nxt     = j_q;
      drain_nxt = drain_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_u1_start) begin
               state_nxt = S_RUN;
               s_nxt     = '0;
               j_nxt     = '0;
            end
         end
         S_RUN: begin
            j_nxt = j_q + JW'(1);
            if (j_q == {JW{1'b1}}) begin
               state_nxt = S_DRAIN;
               drain_nxt = DCW'(L);
            end
         end
         S_DRAIN: begin
            drain_nxt = drain_q - DCW'(1);
            if (drain_q == DCW'(1)) begin
               if (s_q == LAST_S) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_RUN;
                  s_nxt     = s_q + 4'd1;
                  j_nxt     = '0;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            s_nxt     = '0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Butterfly address/twiddle generation for the read issued next cycle
   always_comb begin
      rd_nxt_c = (state_nxt == S_RUN);
      half_c   = AW'(1) << s_nxt;
      pos_c    = AW'(j_nxt) & (half_c - AW'(1));
      grp_c    = AW'(j_nxt) >> s_nxt;
      addr_a_c = (grp_c << (5'(s_nxt) + 5'd1)) | pos_c;
      addr_b_c = addr_a_c + half_c;
      tw_c     = JW'(pos_c << (LAST_S - s_nxt));
   end

   // Registered read-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_u1_busy     <= 1'b0;
         o_u1_done     <= 1'b0;
         o_u1_rd_en    <= 1'b0;
         o_rd_addr_a   <= '0;
         o_rd_addr_b   <= '0;
         o_twiddle_idx <= '0;
      end else begin
         o_u1_busy     <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
         o_u1_done     <= (state_nxt == S_DONE);
         o_u1_rd_en    <= rd_nxt_c;
         o_rd_addr_a   <= rd_nxt_c ? addr_a_c : '0;
         o_rd_addr_b   <= rd_nxt_c ? addr_b_c : '0;
         o_twiddle_idx <= rd_nxt_c ? tw_c : '0;
      end
   end

   // Read-to-write delay line; shifts every cycle regardless of state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dl_en <= '0;
         for (int unsigned i = 0; i < L; i++) begin
            dl_a[i] <= '0;
            dl_b[i] <= '0;
         end
      end else begin
         dl_en[0] <= o_u1_rd_en;
         dl_a[0]  <= o_rd_addr_a;
         dl_b[0]  <= o_rd_addr_b;
         for (int unsigned i = 1; i < L; i++) begin
            dl_en[i] <= dl_en[i-1];
            dl_a[i]  <= dl_a[i-1];
            dl_b[i]  <= dl_b[i-1];
         end
      end
   end

   assign o_u1_bfly_valid = dl_en[MEM_RD_LAT-1];
   assign o_u1_wr_en      = dl_en[L-1];
   assign o_wr_addr_a     = dl_a[L-1];
   assign o_wr_addr_b     = dl_b[L-1];
   assign o_u4_stage      = s_q;

endmodule
